// File: rtl/id_digit_sequencer_if.sv
// Purpose : control, table-write and digit-output bundle for id_digit_sequencer.
// Latency : n/a (wiring only).
// Backpressure: none; step_en paces playback, writes are always accepted.
// Signals : start/stop/step_en/loop/seq_len (control), wr_en/wr_addr/wr_data (table write),
//           id/idx/busy/done/wr_err (status). master = controller side, slave = sequencer side.
interface id_digit_sequencer_if #(
  parameter int DIGIT_W = 4,
  parameter int MAX_LEN = 8
);
  localparam int AW = $clog2(MAX_LEN);

  logic               start;
  logic               stop;
  logic               step_en;
  logic               loop;
  logic [AW:0]        seq_len;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DIGIT_W-1:0] wr_data;
  logic [DIGIT_W-1:0] id;
  logic [AW-1:0]      idx;
  logic               busy;
  logic               done;
  logic               wr_err;

  modport master (
    output start, stop, step_en, loop, seq_len, wr_en, wr_addr, wr_data,
    input  id, idx, busy, done, wr_err
  );

  modport slave (
    input  start, stop, step_en, loop, seq_len, wr_en, wr_addr, wr_data,
    output id, idx, busy, done, wr_err
  );
endinterface

// File: rtl/id_digit_sequencer.sv
// Purpose : plays a programmable digit sequence from an internal table, one digit per step.
// Latency : id/idx update on the edge that accepts start or step_en; visible next cycle.
// Backpressure: none; the sequencer only advances when step_en is high in RUN.
// Ports   : clk, reset (sync, active-high), sq (id_digit_sequencer_if.slave).
// Option  : define BCD_CHECK_EN to reject writes with data > 9 and pulse wr_err.
module id_digit_sequencer #(
  parameter int DIGIT_W = 4,
  parameter int MAX_LEN = 8
) (
  input  logic                clk,
  input  logic                reset,
  id_digit_sequencer_if.slave sq
);
  localparam int          AW      = $clog2(MAX_LEN);
  localparam logic [AW:0] LEN_MAX = (AW+1)'(MAX_LEN);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             r_state;
  logic [DIGIT_W-1:0] r_tbl [MAX_LEN];
  logic [AW:0]        r_len;
  logic [AW-1:0]      r_idx;
  logic [DIGIT_W-1:0] r_id;
  logic               r_busy;
  logic               r_done;

  state_t             w_state_nxt;
  logic [AW:0]        w_len_nxt;
  logic [AW-1:0]      w_idx_nxt;
  logic [AW-1:0]      w_rd_addr;
  logic               w_load;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic               w_len_ok;
  logic               w_last;
  logic               w_addr_ok;
  logic               w_data_ok;
  logic               w_wr;

  assign w_len_ok = (sq.seq_len != '0) && (sq.seq_len <= LEN_MAX);
  // idx is the last entry when idx+1 == len (AW+1 bit compare avoids wrap)
  assign w_last   = (({1'b0, r_idx} + (AW+1)'(1)) == r_len);

  // With a power-of-two table every encodable address is in range.
  generate
    if (MAX_LEN == (1 << AW)) begin : g_pow2
      assign w_addr_ok = 1'b1;
    end else begin : g_npow2
      assign w_addr_ok = ({1'b0, sq.wr_addr} < LEN_MAX);
    end
  endgenerate

`ifdef BCD_CHECK_EN
  logic r_wr_err;
  assign w_data_ok = (sq.wr_data <= DIGIT_W'(9));
  // Flags bad data even when the address is out of range.
  always_ff @(posedge clk) begin
    if (reset) r_wr_err <= 1'b0;
    else       r_wr_err <= sq.wr_en && !w_data_ok;
  end
  assign sq.wr_err = r_wr_err;
`else
  assign w_data_ok = 1'b1;
  assign sq.wr_err = 1'b0;
`endif

  assign w_wr = sq.wr_en && w_addr_ok && w_data_ok;

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_idx_nxt   = r_idx;
    w_rd_addr   = r_idx;
    w_load      = 1'b0;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (sq.start && w_len_ok) begin
          w_state_nxt = RUN;
          w_len_nxt   = sq.seq_len;
          w_idx_nxt   = '0;
          w_rd_addr   = '0;
          w_load      = 1'b1;
          w_busy_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (sq.stop) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
        end else if (sq.step_en) begin
          if (!w_last) begin
            w_idx_nxt = r_idx + AW'(1);
            w_rd_addr = r_idx + AW'(1);
            w_load    = 1'b1;
          end else if (sq.loop) begin
            w_idx_nxt = '0;
            w_rd_addr = '0;
            w_load    = 1'b1;
          end else begin
            // one-shot end: id/idx stay on the last digit
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_idx   <= '0;
      r_id    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_idx   <= w_idx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      // Table read sees pre-write contents on a same-edge write.
      if (w_load) r_id <= r_tbl[w_rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) r_tbl[i] <= '0;
    end else if (w_wr) begin
      r_tbl[sq.wr_addr] <= sq.wr_data;
    end
  end

  assign sq.id   = r_id;
  assign sq.idx  = r_idx;
  assign sq.busy = r_busy;
  assign sq.done = r_done;
endmodule

// File: tb/tb_id_digit_sequencer.sv
module tb_id_digit_sequencer;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  id_digit_sequencer_if #(.DIGIT_W(4), .MAX_LEN(8)) sq ();

  id_digit_sequencer #(.DIGIT_W(4), .MAX_LEN(8)) dut (
    .clk   (clk),
    .reset (reset),
    .sq    (sq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] d);
    sq.wr_en = 1'b1; sq.wr_addr = a; sq.wr_data = d;
    tick();
    sq.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_vec++; if (sq.id !== 4'd0) begin n_err++; $display("FAIL reset_id got=%0d exp=0", sq.id); end
    n_vec++; if (sq.idx !== 3'd0) begin n_err++; $display("FAIL reset_idx got=%0d exp=0", sq.idx); end
    n_vec++; if (sq.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", sq.busy); end
    n_vec++; if (sq.done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", sq.done); end
    n_vec++; if (sq.wr_err !== 1'b0) begin n_err++; $display("FAIL reset_wr_err got=%b exp=0", sq.wr_err); end
  endtask

  task automatic test_oneshot();
    logic [3:0] exp_id [4];
    exp_id = '{4'd3, 4'd1, 4'd4, 4'd1};
    wr(3'd0, 4'd3); wr(3'd1, 4'd1); wr(3'd2, 4'd4); wr(3'd3, 4'd1);
    sq.start = 1'b1; sq.seq_len = 4'd4; sq.loop = 1'b0;
    tick();
    sq.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (sq.id !== exp_id[i] || sq.idx !== 3'(i) || sq.busy !== 1'b1 || sq.done !== 1'b0) begin
        n_err++;
        $display("FAIL oneshot_step%0d got id=%0d idx=%0d busy=%b done=%b exp id=%0d idx=%0d busy=1 done=0",
                 i, sq.id, sq.idx, sq.busy, sq.done, exp_id[i], i);
      end
      sq.step_en = 1'b1;
      tick();
    end
    sq.step_en = 1'b0;
    n_vec++;
    if (sq.done !== 1'b1 || sq.busy !== 1'b0 || sq.id !== 4'd1 || sq.idx !== 3'd3) begin
      n_err++;
      $display("FAIL oneshot_end got done=%b busy=%b id=%0d idx=%0d exp done=1 busy=0 id=1 idx=3",
               sq.done, sq.busy, sq.id, sq.idx);
    end
    tick();
    n_vec++;
    if (sq.done !== 1'b0 || sq.id !== 4'd1) begin
      n_err++; $display("FAIL oneshot_done_pulse got done=%b id=%0d exp done=0 id=1", sq.done, sq.id);
    end
  endtask

  task automatic test_loop();
    logic [3:0] exp_id  [7];
    logic [2:0] exp_idx [7];
    exp_id  = '{4'd3, 4'd1, 4'd4, 4'd3, 4'd1, 4'd4, 4'd3};
    exp_idx = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0};
    sq.start = 1'b1; sq.seq_len = 4'd3; sq.loop = 1'b1;
    tick();
    sq.start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      n_vec++;
      if (sq.id !== exp_id[i] || sq.idx !== exp_idx[i] || sq.done !== 1'b0 || sq.busy !== 1'b1) begin
        n_err++;
        $display("FAIL loop_step%0d got id=%0d idx=%0d done=%b busy=%b exp id=%0d idx=%0d done=0 busy=1",
                 i, sq.id, sq.idx, sq.done, sq.busy, exp_id[i], exp_idx[i]);
      end
      if (i < 6) begin
        sq.step_en = 1'b1;
        tick();
      end
    end
    sq.step_en = 1'b0;
  endtask

  task automatic test_stop();
    // continue from loop test: RUN at idx 0, advance to idx 2
    sq.step_en = 1'b1;
    tick(); tick();
    n_vec++; if (sq.idx !== 3'd2 || sq.id !== 4'd4) begin n_err++; $display("FAIL stop_pre got idx=%0d id=%0d exp idx=2 id=4", sq.idx, sq.id); end
    sq.stop = 1'b1;
    tick();
    sq.stop = 1'b0; sq.step_en = 1'b0;
    n_vec++;
    if (sq.busy !== 1'b0 || sq.idx !== 3'd2 || sq.id !== 4'd4 || sq.done !== 1'b0) begin
      n_err++; $display("FAIL stop_hold got busy=%b idx=%0d id=%0d done=%b exp busy=0 idx=2 id=4 done=0", sq.busy, sq.idx, sq.id, sq.done);
    end
    sq.start = 1'b1; sq.seq_len = 4'd0;
    tick();
    n_vec++; if (sq.busy !== 1'b0 || sq.idx !== 3'd2) begin n_err++; $display("FAIL start_len0 got busy=%b idx=%0d exp busy=0 idx=2", sq.busy, sq.idx); end
    sq.seq_len = 4'd9;
    tick();
    sq.start = 1'b0;
    n_vec++; if (sq.busy !== 1'b0) begin n_err++; $display("FAIL start_len9 got busy=%b exp 0", sq.busy); end
  endtask

  task automatic test_rw_same_edge();
    sq.start = 1'b1; sq.seq_len = 4'd3; sq.loop = 1'b1;
    tick();
    sq.start = 1'b0;
    sq.step_en = 1'b1;
    sq.wr_en = 1'b1; sq.wr_addr = 3'd1; sq.wr_data = 4'd7;
    tick();
    sq.wr_en = 1'b0;
    n_vec++; if (sq.id !== 4'd1 || sq.idx !== 3'd1) begin n_err++; $display("FAIL rw_old_data got id=%0d idx=%0d exp id=1 idx=1", sq.id, sq.idx); end
    tick(); tick(); tick();
    n_vec++; if (sq.id !== 4'd7 || sq.idx !== 3'd1) begin n_err++; $display("FAIL rw_new_data got id=%0d idx=%0d exp id=7 idx=1", sq.id, sq.idx); end
    sq.step_en = 1'b0; sq.stop = 1'b1;
    tick();
    sq.stop = 1'b0;
    n_vec++; if (sq.busy !== 1'b0) begin n_err++; $display("FAIL rw_stop got busy=%b exp 0", sq.busy); end
  endtask

  task automatic test_reset_midrun();
    sq.start = 1'b1; sq.seq_len = 4'd4; sq.loop = 1'b0;
    tick();
    sq.start = 1'b0; sq.step_en = 1'b1;
    tick(); tick(); tick();
    sq.step_en = 1'b0;
    n_vec++; if (sq.idx !== 3'd3 || sq.id !== 4'd1) begin n_err++; $display("FAIL midrun_pre got idx=%0d id=%0d exp idx=3 id=1", sq.idx, sq.id); end
    reset = 1'b1;
    sq.step_en = 1'b1;
    tick();
    reset = 1'b0; sq.step_en = 1'b0;
    n_vec++;
    if (sq.id !== 4'd0 || sq.idx !== 3'd0 || sq.busy !== 1'b0 || sq.done !== 1'b0) begin
      n_err++; $display("FAIL midrun_reset got id=%0d idx=%0d busy=%b done=%b exp all 0", sq.id, sq.idx, sq.busy, sq.done);
    end
    sq.start = 1'b1; sq.seq_len = 4'd4;
    tick();
    sq.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (sq.id !== 4'd0 || sq.idx !== 3'(i) || sq.busy !== 1'b1) begin
        n_err++; $display("FAIL cleared_step%0d got id=%0d idx=%0d busy=%b exp id=0 idx=%0d busy=1", i, sq.id, sq.idx, sq.busy, i);
      end
      sq.step_en = 1'b1;
      tick();
    end
    sq.step_en = 1'b0;
    n_vec++; if (sq.done !== 1'b1 || sq.busy !== 1'b0) begin n_err++; $display("FAIL cleared_done got done=%b busy=%b exp done=1 busy=0", sq.done, sq.busy); end
  endtask

  task automatic test_bcd();
    logic       exp_err;
    logic [3:0] exp_t0;
`ifdef BCD_CHECK_EN
    exp_err = 1'b1; exp_t0 = 4'd0;
`else
    exp_err = 1'b0; exp_t0 = 4'd12;
`endif
    wr(3'd0, 4'd12);
    n_vec++; if (sq.wr_err !== exp_err) begin n_err++; $display("FAIL bcd_err got=%b exp=%b", sq.wr_err, exp_err); end
    tick();
    n_vec++; if (sq.wr_err !== 1'b0) begin n_err++; $display("FAIL bcd_err_pulse got=%b exp=0", sq.wr_err); end
    wr(3'd1, 4'd9);
    n_vec++; if (sq.wr_err !== 1'b0) begin n_err++; $display("FAIL bcd_valid got=%b exp=0", sq.wr_err); end
    // len=1 one-shot: shows entry 0, first step ends the sequence
    sq.start = 1'b1; sq.seq_len = 4'd1; sq.loop = 1'b0;
    tick();
    sq.start = 1'b0;
    n_vec++; if (sq.id !== exp_t0 || sq.busy !== 1'b1) begin n_err++; $display("FAIL bcd_table got id=%0d busy=%b exp id=%0d busy=1", sq.id, sq.busy, exp_t0); end
    sq.step_en = 1'b1;
    tick();
    sq.step_en = 1'b0;
    n_vec++;
    if (sq.done !== 1'b1 || sq.busy !== 1'b0 || sq.id !== exp_t0) begin
      n_err++; $display("FAIL len1_done got done=%b busy=%b id=%0d exp done=1 busy=0 id=%0d", sq.done, sq.busy, sq.id, exp_t0);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1;
    sq.start = 1'b0; sq.stop = 1'b0; sq.step_en = 1'b0; sq.loop = 1'b0; sq.seq_len = '0;
    sq.wr_en = 1'b0; sq.wr_addr = '0; sq.wr_data = '0;
    test_reset();
    test_oneshot();
    test_loop();
    test_stop();
    test_rw_same_edge();
    test_reset_midrun();
    test_reset();
    test_bcd();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
